// File: rtl/cmvm_pkg.sv
// cmvm_pkg: shared types and sizing helpers for the
// shift-add constant-matrix x vector multiplier.
package cmvm_pkg;

  localparam int SHIFT_W = 4;

  typedef struct packed {
    logic               valid;
    logic               neg;
    logic [SHIFT_W-1:0] shift;
  } coef_term_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int fld_w(input int cnt);
    return (cnt <= 1) ? 1 : $clog2(cnt);
  endfunction

  function automatic int shift_w(input int max_shift);
    return $clog2(max_shift + 1);
  endfunction

  function automatic int acc_w(
    input int data_w,
    input int max_shift,
    input int n,
    input int terms
  );
    return data_w + max_shift + $clog2(n * terms) + 1;
  endfunction

  function automatic logic ovf64(
    input logic signed [63:0] a,
    input int                 dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    return (a > hi) || (a < lo);
  endfunction

  function automatic logic signed [63:0] sat64(
    input logic signed [63:0] a,
    input int                 dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (a > hi) return hi;
    if (a < lo) return lo;
    return a;
  endfunction

endpackage

// File: rtl/cmvm_term_sum.sv
// cmvm_term_sum: one matrix entry applied to one lane,
// summed as signed power-of-two terms.
module cmvm_term_sum
  import cmvm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TERMS  = 4,
  parameter int ACC_W  = 52
) (
  input  coef_term_t [TERMS-1:0]   terms,
  input  logic signed [DATA_W-1:0] v,
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] part;

  always_comb begin
    ext  = {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    sum  = '0;
    part = '0;
    for (int t = 0; t < TERMS; t++) begin
      if (terms[t].valid) begin
        part = ext <<< terms[t].shift;
        sum  = terms[t].neg ? sum - part : sum + part;
      end
    end
  end

endmodule

// File: rtl/cmvm_shift_add_seq.sv
// cmvm_shift_add_seq: z = M[sel] * v, one column per
// cycle, with a loadable power-of-two coefficient store.
module cmvm_shift_add_seq
  import cmvm_pkg::*;
#(
  parameter int N            = 4,
  parameter int DATA_W       = 32,
  parameter int NUM_MATRICES = 20,
  parameter int TERMS        = 4,
  parameter int MAX_SHIFT    = 15,
  parameter bit SATURATE     = 1'b1,
  localparam int SEL_W  = fld_w(NUM_MATRICES),
  localparam int ROW_W  = fld_w(N),
  localparam int TERM_W = fld_w(TERMS),
  localparam int ADDR_W = SEL_W + 2 * ROW_W + TERM_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   in_v,
  input  logic [SEL_W-1:0]      in_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*DATA_W-1:0]   out_z,
  output logic [N-1:0]          out_ovf,
  output logic                  out_err,
  input  logic                  coef_we,
  input  logic [ADDR_W-1:0]     coef_addr,
  input  logic [SHIFT_W+1:0]    coef_data,
  output logic                  coef_err
);

  localparam int ACC_W = acc_w(DATA_W, MAX_SHIFT, N, TERMS);
  localparam int DEPTH = NUM_MATRICES * N * N * TERMS;
  localparam int IDX_W = fld_w(DEPTH);

  state_e                  state_q, state_d;
  logic [ROW_W-1:0]        col_q, col_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    err_q, err_d;
  logic [N*DATA_W-1:0]     v_q, v_d;
  logic signed [ACC_W-1:0] acc_q [N];
  logic signed [ACC_W-1:0] acc_d [N];
  logic [N*DATA_W-1:0]     out_z_q, out_z_d;
  logic [N-1:0]            out_ovf_q, out_ovf_d;
  logic                    out_err_q, out_err_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready_q, in_ready_d;
  logic                    coef_err_q, coef_err_d;

  coef_term_t              mem_q [DEPTH];
  coef_term_t [TERMS-1:0]  row_terms [N];
  logic signed [ACC_W-1:0] row_sum [N];
  logic signed [DATA_W-1:0] lane;
  logic [SEL_W-1:0]        sel_eff;

  logic [SEL_W-1:0]        wr_mat;
  logic [ROW_W-1:0]        wr_row;
  logic [ROW_W-1:0]        wr_col;
  logic [TERM_W-1:0]       wr_term;
  logic                    wr_bad;
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;

  assign {wr_mat, wr_row, wr_col, wr_term} = coef_addr;

  always_comb begin
    wr_bad = (int'(wr_mat) >= NUM_MATRICES) ||
             (int'(wr_row) >= N) ||
             (int'(wr_col) >= N) ||
             (int'(wr_term) >= TERMS);
    wr_en  = coef_we && (state_q == IDLE) && !wr_bad;
    wr_idx = IDX_W'(((int'(wr_mat) * N + int'(wr_row)) * N
             + int'(wr_col)) * TERMS + int'(wr_term));
  end

  // Store is deliberately left out of reset so contents survive aborts.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= coef_term_t'(coef_data);
  end

  always_comb begin
    sel_eff = err_q ? '0 : sel_q;
    lane    = v_q[int'(col_q)*DATA_W +: DATA_W];
    for (int r = 0; r < N; r++) begin
      for (int t = 0; t < TERMS; t++) begin
        row_terms[r][t] = mem_q[IDX_W'(((int'(sel_eff) * N + r) * N
                          + int'(col_q)) * TERMS + t)];
        if (err_q) row_terms[r][t].valid = 1'b0;
      end
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    cmvm_term_sum #(
      .DATA_W(DATA_W),
      .TERMS (TERMS),
      .ACC_W (ACC_W)
    ) u_sum (
      .terms(row_terms[r]),
      .v    (lane),
      .sum  (row_sum[r])
    );
  end

  always_comb begin
    logic signed [63:0] wide;
    logic signed [63:0] sat;
    state_d     = state_q;
    col_d       = col_q;
    sel_d       = sel_q;
    err_d       = err_q;
    v_d         = v_q;
    acc_d       = acc_q;
    out_z_d     = out_z_q;
    out_ovf_d   = out_ovf_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    wide        = '0;
    sat         = '0;
    coef_err_d  = coef_we && ((state_q != IDLE) || wr_bad);
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = RUN;
          v_d        = in_v;
          sel_d      = in_sel;
          err_d      = int'(in_sel) >= NUM_MATRICES;
          col_d      = '0;
          in_ready_d = 1'b0;
          for (int r = 0; r < N; r++) acc_d[r] = '0;
        end
      end
      RUN: begin
        for (int r = 0; r < N; r++) acc_d[r] = acc_q[r] + row_sum[r];
        col_d = col_q + 1'b1;
        if (int'(col_q) == N - 1) begin
          state_d     = DONE;
          col_d       = '0;
          out_valid_d = 1'b1;
          out_err_d   = err_q;
          for (int r = 0; r < N; r++) begin
            wide = {{(64-ACC_W){acc_d[r][ACC_W-1]}}, acc_d[r]};
            sat  = sat64(wide, DATA_W);
            out_ovf_d[r] = ovf64(wide, DATA_W);
            out_z_d[r*DATA_W +: DATA_W] = SATURATE ?
              sat[DATA_W-1:0] : acc_d[r][DATA_W-1:0];
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      sel_q       <= '0;
      err_q       <= 1'b0;
      v_q         <= '0;
      out_z_q     <= '0;
      out_ovf_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      coef_err_q  <= 1'b0;
      for (int r = 0; r < N; r++) acc_q[r] <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      v_q         <= v_d;
      out_z_q     <= out_z_d;
      out_ovf_q   <= out_ovf_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      coef_err_q  <= coef_err_d;
      for (int r = 0; r < N; r++) acc_q[r] <= acc_d[r];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_ovf   = out_ovf_q;
  assign out_err   = out_err_q;
  assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_cmvm_shift_add_seq.sv
// tb_cmvm_shift_add_seq: scoreboard bench driving a saturating
// and a wrapping instance with identical stimulus.
module tb_cmvm_shift_add_seq;

  localparam int N  = 4;
  localparam int NM = 20;
  localparam int T  = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready, in_ready_w;
  logic [127:0] in_v;
  logic [4:0]   in_sel;
  logic         out_valid, out_valid_w;
  logic         out_ready;
  logic [127:0] out_z, out_z_w;
  logic [3:0]   out_ovf, out_ovf_w;
  logic         out_err, out_err_w;
  logic         coef_we;
  logic [10:0]  coef_addr;
  logic [5:0]   coef_data;
  logic         coef_err, coef_err_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmvm_shift_add_seq u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_v(in_v), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_ovf(out_ovf), .out_err(out_err),
    .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_err(coef_err)
  );

  cmvm_shift_add_seq #(.SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_w),
    .in_v(in_v), .in_sel(in_sel),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .out_z(out_z_w), .out_ovf(out_ovf_w), .out_err(out_err_w),
    .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_err(coef_err_w)
  );

  logic [5:0] mm [NM][N][N][T];

  typedef struct {
    logic [127:0] zs;
    logic [127:0] zw;
    logic [3:0]   ovf;
    logic         err;
  } exp_t;

  exp_t sb[$];

  function automatic logic [127:0] pack4(
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  function automatic exp_t model(input logic [127:0] v, input logic [4:0] sel);
    exp_t e;
    longint acc, ln, term;
    logic [5:0] cf;
    e.zs = '0; e.zw = '0; e.ovf = '0;
    e.err = (int'(sel) >= NM);
    if (!e.err) begin
      for (int r = 0; r < N; r++) begin
        acc = 0;
        for (int c = 0; c < N; c++) begin
          ln = longint'($signed(v[c*32 +: 32]));
          for (int t = 0; t < T; t++) begin
            cf = mm[sel][r][c][t];
            if (cf[5]) begin
              term = ln <<< cf[3:0];
              acc = cf[4] ? acc - term : acc + term;
            end
          end
        end
        e.zw[r*32 +: 32] = acc[31:0];
        if (acc > 64'sh7FFFFFFF) begin
          e.ovf[r] = 1'b1;
          e.zs[r*32 +: 32] = 32'h7FFFFFFF;
        end else if (acc < -64'sh80000000) begin
          e.ovf[r] = 1'b1;
          e.zs[r*32 +: 32] = 32'h80000000;
        end else begin
          e.zs[r*32 +: 32] = acc[31:0];
        end
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output z=%h", out_z);
      end else begin
        e = sb.pop_front();
        if (out_z !== e.zs || out_ovf !== e.ovf || out_err !== e.err) begin
          errors++;
          $display("FAIL result_sat got z=%h ovf=%b err=%b want z=%h ovf=%b err=%b",
                   out_z, out_ovf, out_err, e.zs, e.ovf, e.err);
        end
        checks++;
        if (out_valid_w !== 1'b1 || out_z_w !== e.zw ||
            out_ovf_w !== e.ovf || out_err_w !== e.err) begin
          errors++;
          $display("FAIL result_wrap got v=%b z=%h ovf=%b err=%b want z=%h ovf=%b err=%b",
                   out_valid_w, out_z_w, out_ovf_w, out_err_w, e.zw, e.ovf, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [127:0] v, input logic [4:0] sel);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL req_timeout in_ready=%b want 1", in_ready);
    end else begin
      in_valid = 1'b1;
      in_v     = v;
      in_sel   = sel;
      sb.push_back(model(v, sel));
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d want 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  task automatic wr_coef(input logic [4:0] m, input logic [1:0] r,
                         input logic [1:0] c, input logic [1:0] t,
                         input logic [5:0] d);
    coef_we   = 1'b1;
    coef_addr = {m, r, c, t};
    coef_data = d;
    mm[m][r][c][t] = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_z !== '0 || out_ovf !== '0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got z=%h ovf=%b err=%b want 0", out_z, out_ovf, out_err);
    end
    checks++;
    if (coef_err !== 1'b0) begin
      errors++; $display("FAIL reset_coef_err got %b want 0", coef_err);
    end
  endtask

  task automatic load_store();
    for (int m = 0; m < 5; m++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          for (int t = 0; t < T; t++)
            wr_coef(5'(m), 2'(r), 2'(c), 2'(t),
                    (m == 4) ? 6'($urandom_range(0, 63)) : 6'd0);
  endtask

  task automatic test_identity();
    int n = 0;
    for (int i = 0; i < N; i++) wr_coef(5'd0, 2'(i), 2'(i), 2'd0, 6'b100000);
    do_req(pack4(1, 2, 3, -4), 5'd0);
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL identity_latency got %0d want 4", n);
    end
    wait_drain();
  endtask

  task automatic test_shift_add();
    wr_coef(5'd1, 2'd0, 2'd0, 2'd0, 6'b100011);
    wr_coef(5'd1, 2'd0, 2'd0, 2'd1, 6'b110000);
    wr_coef(5'd1, 2'd1, 2'd2, 2'd0, 6'b110010);
    do_req(pack4(5, 9, -3, 9), 5'd1);
    wait_drain();
    do_req(pack4(-7, 0, 100, 1), 5'd1);
    wait_drain();
  endtask

  task automatic test_saturate();
    wr_coef(5'd2, 2'd0, 2'd0, 2'd0, 6'b101111);
    do_req(pack4(32'h7FFFFFFF, 0, 0, 0), 5'd2);
    wait_drain();
    do_req(pack4(32'h80000000, 1, 0, 0), 5'd2);
    wait_drain();
    do_req(pack4(32'h0000FFFF, 0, 0, 0), 5'd2);
    wait_drain();
    do_req(pack4(32'h00010000, 0, 0, 0), 5'd2);
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    int n = 0;
    out_ready = 1'b0;
    do_req(pack4(7, -8, 100, 0), 5'd1);
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    held     = out_z;
    in_valid = 1'b1;
    in_v     = pack4(11, 22, 33, 44);
    in_sel   = 5'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_z !== held) begin
        errors++;
        $display("FAIL hold_output got v=%b z=%h want v=1 z=%h", out_valid, out_z, held);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_in_ready got %b want 0", in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    do_req(pack4(11, 22, 33, 44), 5'd0);
    wait_drain();
  endtask

  task automatic test_coef_err();
    do_req(pack4(1, 2, 3, 4), 5'd0);
    coef_we   = 1'b1;
    coef_addr = {5'd0, 2'd0, 2'd0, 2'd0};
    coef_data = 6'b100101;
    tick();
    coef_we = 1'b0;
    checks++;
    if (coef_err !== 1'b1) begin
      errors++; $display("FAIL run_write_err got %b want 1", coef_err);
    end
    tick();
    checks++;
    if (coef_err !== 1'b0) begin
      errors++; $display("FAIL run_write_err_pulse got %b want 0", coef_err);
    end
    wait_drain();
    do_req(pack4(-9, 8, -7, 6), 5'd0);
    wait_drain();
    coef_we   = 1'b1;
    coef_addr = {5'd25, 2'd0, 2'd0, 2'd0};
    coef_data = 6'b100001;
    tick();
    coef_we = 1'b0;
    checks++;
    if (coef_err !== 1'b1) begin
      errors++; $display("FAIL bad_addr_err got %b want 1", coef_err);
    end
    tick();
    do_req(pack4(5, 5, 5, 5), 5'd20);
    wait_drain();
    do_req(pack4(-1, 2, -3, 4), 5'd31);
    wait_drain();
  endtask

  task automatic test_same_cycle();
    coef_we   = 1'b1;
    coef_addr = {5'd3, 2'd2, 2'd1, 2'd0};
    coef_data = 6'b100001;
    mm[3][2][1][0] = 6'b100001;
    do_req(pack4(0, 6, 0, 0), 5'd3);
    coef_we = 1'b0;
    checks++;
    if (coef_err !== 1'b0) begin
      errors++; $display("FAIL same_cycle_err got %b want 0", coef_err);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid_run();
    do_req(pack4(3, 3, 3, 3), 5'd0);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_state got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_abort got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    do_req(pack4(2, -2, 4, -4), 5'd0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [4:0] sel;
    for (int i = 0; i < 10; i++) begin
      sel = (i % 5 == 4) ? 5'(20 + i) : 5'($urandom_range(0, 4));
      do_req({$urandom, $urandom, $urandom, $urandom}, sel);
    end
    wait_drain();
  endtask

  initial begin
    for (int m = 0; m < NM; m++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          for (int t = 0; t < T; t++)
            mm[m][r][c][t] = 6'd0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_v      = '0;
    in_sel    = '0;
    out_ready = 1'b1;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    test_reset();
    load_store();
    test_identity();
    test_shift_add();
    test_saturate();
    test_backpressure();
    test_coef_err();
    test_same_cycle();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
